// File: rtl/mul_div_pkg.sv
// Shared encodings for the multiply/divide sequencer: operand width, op codes, FSM states.
package mul_div_pkg;
   localparam int WORD_WIDTH = 32;

   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_DIV  = 3'd1;
   localparam logic [2:0] OP_DIVU = 3'd2;
   localparam logic [2:0] OP_REM  = 3'd3;
   localparam logic [2:0] OP_REMU = 3'd4;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_MUL_WAIT = 2'd1;
   localparam logic [1:0] ST_DIV_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [WORD_WIDTH-1:0] abs_if(input logic neg, input logic [WORD_WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction
endpackage

// File: rtl/mul_div_comb_mult.sv
// Combinational multiplier, low half of the product only; timed as a multicycle path.
module mul_div_comb_mult (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] product_lo
);
   assign product_lo = a * b;
endmodule

// File: rtl/mul_div_div_step_unit.sv
// Unsigned restoring divider core, one quotient bit per step; built only with MULDIV_DIVIDE_EN.
`ifdef MULDIV_DIVIDE_EN
module div_step_unit
   import mul_div_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  step,
   input  logic [WORD_WIDTH-1:0] dividend,
   input  logic [WORD_WIDTH-1:0] divisor,
   output logic [WORD_WIDTH-1:0] quotient,
   output logic [WORD_WIDTH-1:0] remainder
);
   logic [WORD_WIDTH-1:0] quo_reg, rem_reg, dsr_reg;
   logic [WORD_WIDTH:0]   shifted, trial;

   // Remainder shifted with the next dividend bit needs one extra bit before the trial subtract.
   always_comb begin
      shifted = {rem_reg, quo_reg[WORD_WIDTH-1]};
      trial   = shifted - {1'b0, dsr_reg};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_reg <= '0;
         rem_reg <= '0;
         dsr_reg <= '0;
      end else if (load) begin
         quo_reg <= dividend;
         rem_reg <= '0;
         dsr_reg <= divisor;
      end else if (step) begin
         quo_reg <= {quo_reg[WORD_WIDTH-2:0], ~trial[WORD_WIDTH]};
         rem_reg <= trial[WORD_WIDTH] ? shifted[WORD_WIDTH-1:0] : trial[WORD_WIDTH-1:0];
      end
   end

   assign quotient  = quo_reg;
   assign remainder = rem_reg;
endmodule
`endif

// File: rtl/mul_div_sequencer.sv
// Multi-cycle MUL/DIV controller with start/busy/done handshake.
// Define MULDIV_DIVIDE_EN to build the divider; otherwise div/rem ops complete at once as divide-by-zero.
module mul_div_sequencer
   import mul_div_pkg::*;
#(
   parameter int MUL_LATENCY = 2
`ifdef MULDIV_DIVIDE_EN
   , parameter int DIV_STEPS = 32
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [WORD_WIDTH-1:0] leftOperand,
   input  logic [WORD_WIDTH-1:0] rightOperand,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] result,
   output logic                  divByZero
);
   logic [1:0]            state_reg;
   logic [2:0]            mul_cnt_reg;
   logic [WORD_WIDTH-1:0] left_reg, right_reg, result_reg;
   logic                  dbz_reg;
   logic [WORD_WIDTH-1:0] product_lo;
   logic                  is_div_op;
   logic                  div_finished;
   logic [WORD_WIDTH-1:0] div_final;

   assign is_div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);

   mul_div_comb_mult u_mult (
      .a          (left_reg),
      .b          (right_reg),
      .product_lo (product_lo)
   );

`ifdef MULDIV_DIVIDE_EN
   localparam logic DIV_PRESENT = 1'b1;
   logic [2:0]            op_reg;
   logic [5:0]            step_cnt_reg;
   logic                  div_load, div_step, in_signed, reg_signed;
   logic [WORD_WIDTH-1:0] div_quo, div_rem, signed_quo, signed_rem;

   assign in_signed  = (op == OP_DIV) || (op == OP_REM);
   assign reg_signed = (op_reg == OP_DIV) || (op_reg == OP_REM);
   assign div_load   = (state_reg == ST_IDLE) && start && is_div_op && (rightOperand != '0);
   assign div_step   = (state_reg == ST_DIV_RUN) && (step_cnt_reg != 6'(DIV_STEPS));

   div_step_unit u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .step      (div_step),
      .dividend  (abs_if(in_signed && leftOperand[WORD_WIDTH-1], leftOperand)),
      .divisor   (abs_if(in_signed && rightOperand[WORD_WIDTH-1], rightOperand)),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         op_reg       <= '0;
         step_cnt_reg <= '0;
      end else if (div_load) begin
         op_reg       <= op;
         step_cnt_reg <= '0;
      end else if (div_step) begin
         step_cnt_reg <= step_cnt_reg + 6'd1;
      end
   end

   // Sign fix-up takes the cycle after the last step.
   assign signed_quo   = abs_if(reg_signed && (left_reg[WORD_WIDTH-1] ^ right_reg[WORD_WIDTH-1]), div_quo);
   assign signed_rem   = abs_if(reg_signed && left_reg[WORD_WIDTH-1], div_rem);
   assign div_final    = ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) ? signed_quo : signed_rem;
   assign div_finished = (step_cnt_reg == 6'(DIV_STEPS));
`else
   localparam logic DIV_PRESENT = 1'b0;
   assign div_final    = '0;
   assign div_finished = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         mul_cnt_reg <= '0;
         left_reg    <= '0;
         right_reg   <= '0;
         result_reg  <= '0;
         dbz_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: if (start) begin
               left_reg  <= leftOperand;
               right_reg <= rightOperand;
               if (op == OP_MUL) begin
                  mul_cnt_reg <= 3'(MUL_LATENCY);
                  state_reg   <= ST_MUL_WAIT;
               end else if (is_div_op && (!DIV_PRESENT || (rightOperand == '0))) begin
                  result_reg <= '0;
                  dbz_reg    <= 1'b1;
                  state_reg  <= ST_DONE;
               end else if (is_div_op) begin
                  state_reg <= ST_DIV_RUN;
               end else begin
                  result_reg <= '0;
                  dbz_reg    <= 1'b0;
                  state_reg  <= ST_DONE;
               end
            end
            ST_MUL_WAIT: begin
               mul_cnt_reg <= mul_cnt_reg - 3'd1;
               if (mul_cnt_reg == 3'd1) begin
                  result_reg <= product_lo;
                  dbz_reg    <= 1'b0;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DIV_RUN: if (div_finished) begin
               result_reg <= div_final;
               dbz_reg    <= 1'b0;
               state_reg  <= ST_DONE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state_reg == ST_MUL_WAIT) || (state_reg == ST_DIV_RUN);
   assign done      = (state_reg == ST_DONE);
   assign result    = result_reg;
   assign divByZero = dbz_reg;
endmodule
